// File: rtl/wb_protocol_monitor.sv
// Passive Wishbone classic-cycle monitor: registered per-rule violation flags,
// first-error capture and transfer statistics for the SDRAM controller bus.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transfer outstanding; zero-wait transfers complete here
// WAIT  | strobe accepted, waiting for ack/err/rty; request captured
module wb_protocol_monitor #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic              wb_clk_i,
    input  logic              sdram_resetn,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DW/8-1:0]   wb_sel_i,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_o,
    input  logic              wb_err_o,
    input  logic              wb_rty_o,
    input  logic              err_clr,
    output logic [6:0]        err_vec,
    output logic              err_any,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [2:0]        first_err_rule,
    output logic [AW-1:0]     first_err_adr,
    output logic [CNT_W-1:0]  txn_cnt,
    output logic [CNT_W-1:0]  abort_cnt,
    output logic [CNT_W-1:0]  max_lat
);

    localparam int SW = DW / 8;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int LW = (WW > CNT_W) ? WW : CNT_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WW-1:0]    WAIT_MAX = WW'(TIMEOUT);
    localparam logic [WW-1:0]    WAIT_PRE = WW'(TIMEOUT - 1);

    logic [0:0]    state;
    logic          rst_q;
    logic [AW-1:0] cap_adr;
    logic          cap_we;
    logic [SW-1:0] cap_sel;
    logic [DW-1:0] cap_dat;
    logic [WW-1:0] wait_cnt;

    logic          term;
    logic          req;
    logic          in_wait;
    logic          stay;
    logic          viol;
    logic [6:0]    rule;
    logic [LW-1:0] wait_ext;
    logic [LW-1:0] max_ext;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [2:0] lowest_rule(input logic [6:0] r);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (r[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign term    = wb_ack_o | wb_err_o | wb_rty_o;
    assign req     = wb_cyc_i & wb_stb_i;
    assign in_wait = (state == S_WAIT);
    // The cycle in which WAIT neither exits nor ends: the wait counter advances.
    assign stay    = in_wait & ~wb_rst_i & wb_cyc_i & ~term & wb_stb_i;
    assign viol    = |rule;
    assign err_any = |err_vec;

    assign wait_ext = LW'(wait_cnt);
    assign max_ext  = LW'(max_lat);

    always_comb begin
        rule    = 7'd0;
        rule[0] = wb_rst_i & rst_q & (wb_cyc_i | wb_stb_i);
        rule[1] = wb_stb_i & ~wb_cyc_i;
        rule[2] = term & ~req;
        rule[3] = (wb_ack_o & wb_err_o) | (wb_ack_o & wb_rty_o) | (wb_err_o & wb_rty_o);
        rule[4] = in_wait & ((wb_addr_i != cap_adr) || (wb_we_i != cap_we) ||
                             (wb_sel_i != cap_sel) || (cap_we && (wb_dat_i != cap_dat)));
        rule[5] = in_wait & ~wb_stb_i & wb_cyc_i & ~term;
        // Fires only on the step into TIMEOUT; the counter then sits saturated.
        rule[6] = stay & (wait_cnt == WAIT_PRE);
    end

    always_ff @(posedge wb_clk_i or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state     <= S_IDLE;
            rst_q     <= 1'b0;
            cap_adr   <= '0;
            cap_we    <= 1'b0;
            cap_sel   <= '0;
            cap_dat   <= '0;
            wait_cnt  <= '0;
            txn_cnt   <= '0;
            abort_cnt <= '0;
            max_lat   <= '0;
        end else begin
            rst_q <= wb_rst_i;
            case (state)
                S_IDLE: begin
                    if (req && term) begin
                        txn_cnt <= sat_inc(txn_cnt);
                    end else if (req && !wb_rst_i) begin
                        state    <= S_WAIT;
                        cap_adr  <= wb_addr_i;
                        cap_we   <= wb_we_i;
                        cap_sel  <= wb_sel_i;
                        cap_dat  <= wb_dat_i;
                        wait_cnt <= WW'(1);
                    end
                end
                S_WAIT: begin
                    if (wb_rst_i) begin
                        state <= S_IDLE;
                    end else if (!wb_cyc_i) begin
                        state     <= S_IDLE;
                        abort_cnt <= sat_inc(abort_cnt);
                    end else if (term) begin
                        state   <= S_IDLE;
                        txn_cnt <= sat_inc(txn_cnt);
                        if (wait_ext > max_ext) begin
                            max_lat <= (wait_ext > LW'(CNT_MAX)) ? CNT_MAX : CNT_W'(wait_ext);
                        end
                    end else if (!wb_stb_i) begin
                        state <= S_IDLE;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A violation coinciding with err_clr is recorded as a fresh first error.
    always_ff @(posedge wb_clk_i or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            err_vec        <= '0;
            err_cnt        <= '0;
            first_err_rule <= '0;
            first_err_adr  <= '0;
        end else if (err_clr) begin
            err_vec <= rule;
            err_cnt <= viol ? CNT_W'(1) : '0;
            if (viol) begin
                first_err_rule <= lowest_rule(rule);
                first_err_adr  <= wb_addr_i;
            end else begin
                first_err_rule <= '0;
                first_err_adr  <= '0;
            end
        end else begin
            err_vec <= err_vec | rule;
            if (viol) begin
                err_cnt <= sat_inc(err_cnt);
                if (err_cnt == '0) begin
                    first_err_rule <= lowest_rule(rule);
                    first_err_adr  <= wb_addr_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// Directed bench for wb_protocol_monitor: per-cycle vector table plus
// hand-written timeout and asynchronous-reset sequences.
module tb_wb_protocol_monitor;

    logic        wb_clk_i = 1'b0;
    logic        sdram_resetn = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_addr_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_o = 1'b0;
    logic        wb_err_o = 1'b0;
    logic        wb_rty_o = 1'b0;
    logic        err_clr = 1'b0;
    logic [6:0]  err_vec;
    logic        err_any;
    logic [15:0] err_cnt;
    logic [2:0]  first_err_rule;
    logic [31:0] first_err_adr;
    logic [15:0] txn_cnt;
    logic [15:0] abort_cnt;
    logic [15:0] max_lat;

    int n_pass = 0;
    int n_total = 0;

    wb_protocol_monitor #(.AW(32), .DW(32), .TIMEOUT(8), .CNT_W(16)) dut (
        .wb_clk_i(wb_clk_i), .sdram_resetn(sdram_resetn), .wb_rst_i(wb_rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .err_clr(err_clr), .err_vec(err_vec), .err_any(err_any), .err_cnt(err_cnt),
        .first_err_rule(first_err_rule), .first_err_adr(first_err_adr),
        .txn_cnt(txn_cnt), .abort_cnt(abort_cnt), .max_lat(max_lat)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        bit          rb;
        logic        cyc, stb, we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        ack, err, rty, rst, clr;
        logic [6:0]  e_vec;
        logic [15:0] e_cnt;
        logic [2:0]  e_rule;
        logic [31:0] e_adr;
        logic [15:0] e_txn, e_abort, e_lat;
    } vec_t;

    function automatic vec_t mk(input bit rb, input logic cyc, stb, we,
                                input logic [31:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat, input logic ack, err, rty, rst, clr,
                                input logic [6:0] ev, input logic [15:0] ec,
                                input logic [2:0] er, input logic [31:0] ea,
                                input logic [15:0] et, eab, el);
        vec_t v;
        v.rb = rb; v.cyc = cyc; v.stb = stb; v.we = we; v.adr = adr; v.sel = sel;
        v.dat = dat; v.ack = ack; v.err = err; v.rty = rty; v.rst = rst; v.clr = clr;
        v.e_vec = ev; v.e_cnt = ec; v.e_rule = er; v.e_adr = ea;
        v.e_txn = et; v.e_abort = eab; v.e_lat = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic check_all(input string tag, input logic [6:0] ev, input logic [15:0] ec,
                             input logic [2:0] er, input logic [31:0] ea,
                             input logic [15:0] et, eab, el);
        chk({tag, " err_vec"}, 32'(err_vec), 32'(ev));
        chk({tag, " err_any"}, 32'(err_any), 32'(|ev));
        chk({tag, " err_cnt"}, 32'(err_cnt), 32'(ec));
        chk({tag, " first_err_rule"}, 32'(first_err_rule), 32'(er));
        chk({tag, " first_err_adr"}, first_err_adr, ea);
        chk({tag, " txn_cnt"}, 32'(txn_cnt), 32'(et));
        chk({tag, " abort_cnt"}, 32'(abort_cnt), 32'(eab));
        chk({tag, " max_lat"}, 32'(max_lat), 32'(el));
    endtask

    task automatic drive(input logic cyc, stb, we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input logic ack, err, rty, rst, clr);
        wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we; wb_addr_i = adr; wb_sel_i = sel;
        wb_dat_i = dat; wb_ack_o = ack; wb_err_o = err; wb_rty_o = rty;
        wb_rst_i = rst; err_clr = clr;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sdram_resetn = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        sdram_resetn = 1'b1;
    endtask

    vec_t tbl[28];

    initial begin
        // Clean write (latency 3) then zero-wait read
        tbl[0]  = mk(1, 1,1,1, 'h100,'hF,'hDEAD, 0,0,0,0,0,  'h00,0,0,'h000, 0,0,0);
        tbl[1]  = mk(0, 1,1,1, 'h100,'hF,'hDEAD, 0,0,0,0,0,  'h00,0,0,'h000, 0,0,0);
        tbl[2]  = mk(0, 1,1,1, 'h100,'hF,'hDEAD, 0,0,0,0,0,  'h00,0,0,'h000, 0,0,0);
        tbl[3]  = mk(0, 1,1,1, 'h100,'hF,'hDEAD, 1,0,0,0,0,  'h00,0,0,'h000, 1,0,3);
        tbl[4]  = mk(0, 1,1,0, 'h200,'hF,'h0,    1,0,0,0,0,  'h00,0,0,'h000, 2,0,3);
        tbl[5]  = mk(0, 0,0,0, 'h0,  'h0,'h0,    0,0,0,0,0,  'h00,0,0,'h000, 2,0,3);
        // Address changes during WAIT
        tbl[6]  = mk(1, 1,1,1, 'h100,'hF,'h1234, 0,0,0,0,0,  'h00,0,0,'h000, 0,0,0);
        tbl[7]  = mk(0, 1,1,1, 'h104,'hF,'h1234, 0,0,0,0,0,  'h10,1,4,'h104, 0,0,0);
        tbl[8]  = mk(0, 1,1,1, 'h104,'hF,'h1234, 1,0,0,0,0,  'h10,2,4,'h104, 1,0,2);
        tbl[9]  = mk(0, 0,0,0, 'h0,  'h0,'h0,    0,0,0,0,0,  'h10,2,4,'h104, 1,0,2);
        // ack+err together, later stb without cyc
        tbl[10] = mk(1, 1,1,0, 'h300,'hF,'h0,    1,1,0,0,0,  'h08,1,3,'h300, 1,0,0);
        tbl[11] = mk(0, 0,0,0, 'h0,  'h0,'h0,    0,0,0,0,0,  'h08,1,3,'h300, 1,0,0);
        tbl[12] = mk(0, 0,1,0, 'h304,'hF,'h0,    0,0,0,0,0,  'h0A,2,3,'h300, 1,0,0);
        tbl[13] = mk(0, 0,0,0, 'h0,  'h0,'h0,    0,0,0,0,0,  'h0A,2,3,'h300, 1,0,0);
        // Abort, then err_clr colliding with a spurious ack
        tbl[14] = mk(1, 1,1,1, 'h400,'hF,'hAA,   0,0,0,0,0,  'h00,0,0,'h000, 0,0,0);
        tbl[15] = mk(0, 1,1,1, 'h400,'hF,'hAA,   0,0,0,0,0,  'h00,0,0,'h000, 0,0,0);
        tbl[16] = mk(0, 0,0,1, 'h400,'hF,'hAA,   0,0,0,0,0,  'h00,0,0,'h000, 0,1,0);
        tbl[17] = mk(0, 0,1,0, 'h404,'hF,'h0,    0,0,0,0,0,  'h02,1,1,'h404, 0,1,0);
        tbl[18] = mk(0, 0,0,0, 'h0,  'h0,'h0,    0,0,0,0,0,  'h02,1,1,'h404, 0,1,0);
        tbl[19] = mk(0, 0,0,0, 'h408,'h0,'h0,    1,0,0,0,1,  'h04,1,2,'h408, 0,1,0);
        tbl[20] = mk(0, 0,0,0, 'h0,  'h0,'h0,    0,0,0,0,0,  'h04,1,2,'h408, 0,1,0);
        tbl[21] = mk(0, 0,0,0, 'h0,  'h0,'h0,    0,0,0,0,1,  'h00,0,0,'h000, 0,1,0);
        // Held bus reset with request, then strobe drop in WAIT
        tbl[22] = mk(1, 1,1,0, 'h500,'hF,'h0,    0,0,0,1,0,  'h00,0,0,'h000, 0,0,0);
        tbl[23] = mk(0, 1,1,0, 'h500,'hF,'h0,    0,0,0,1,0,  'h01,1,0,'h500, 0,0,0);
        tbl[24] = mk(0, 1,1,0, 'h600,'hF,'h0,    0,0,0,0,0,  'h01,1,0,'h500, 0,0,0);
        tbl[25] = mk(0, 1,0,0, 'h600,'hF,'h0,    0,0,0,0,0,  'h21,2,0,'h500, 0,0,0);
        tbl[26] = mk(0, 1,1,0, 'h700,'hF,'h0,    1,0,0,0,0,  'h21,2,0,'h500, 1,0,0);
        tbl[27] = mk(0, 0,0,0, 'h0,  'h0,'h0,    0,0,0,0,0,  'h21,2,0,'h500, 1,0,0);

        apply_reset();
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            if (tbl[i].rb) apply_reset();
            drive(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat,
                  tbl[i].ack, tbl[i].err, tbl[i].rty, tbl[i].rst, tbl[i].clr);
            @(posedge wb_clk_i);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].e_vec, tbl[i].e_cnt, tbl[i].e_rule,
                      tbl[i].e_adr, tbl[i].e_txn, tbl[i].e_abort, tbl[i].e_lat);
        end

        // Timeout: 12 cycles without termination, then ack
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1, 1, 0, 'h800, 'hF, 0, 0, 0, 0, 0, 0);
            @(posedge wb_clk_i);
            #1;
            chk($sformatf("tmo%0d err_vec", k), 32'(err_vec), (k >= 7) ? 32'h40 : 32'h0);
            chk($sformatf("tmo%0d err_cnt", k), 32'(err_cnt), (k >= 7) ? 32'd1 : 32'd0);
        end
        drive(1, 1, 0, 'h800, 'hF, 0, 1, 0, 0, 0, 0);
        @(posedge wb_clk_i);
        #1;
        check_all("tmo_ack", 'h40, 1, 6, 'h800, 1, 0, 8);

        // Asynchronous reset while a transfer is waiting
        drive(1, 1, 1, 'h900, 'hF, 'h55, 0, 0, 0, 0, 0);
        @(posedge wb_clk_i);
        #3;
        sdram_resetn = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge wb_clk_i);
        sdram_resetn = 1'b1;
        drive(1, 1, 1, 'hA00, 'hF, 'h77, 0, 0, 0, 0, 0);
        @(posedge wb_clk_i);
        #1;
        drive(1, 1, 1, 'hA00, 'hF, 'h77, 1, 0, 0, 0, 0);
        @(posedge wb_clk_i);
        #1;
        check_all("post_rst", 0, 0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge wb_clk_i);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
